inv_mix_columns_seq: RTL and testbench
======================================

INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_state holds a valid 128-bit AES state.
REQ-005 in_ready  output  1  block accepts in_state this cycle.
REQ-006 in_state  input  128  state; column c = bits [127-32c -: 32], byte a0 = MSB of column.
REQ-007 out_valid  output  1  out_state holds the InvMixColumns result.
REQ-008 out_ready  input  1  downstream accepts out_state this cycle.
REQ-009 out_state  output  128  result, same column/byte ordering as in_state.

Function
REQ-010 Per column SHALL compute b0=0E·a0^0B·a1^0D·a2^09·a3, b1=09·a0^0E·a1^0B·a2^0D·a3, b2=0D·a0^09·a1^0E·a2^0B·a3, b3=0B·a0^0D·a1^09·a2^0E·a3 over GF(2^8), polynomial 0x11B.
REQ-011 GF products SHALL be built from xtime (shift left 1, XOR 0x1B if bit 7 set): x9=x8^x, xB=x8^x2^x, xD=x8^x4^x, xE=x8^x4^x2; all results 8 bits.
REQ-012 Exactly one column SHALL be processed per cycle through a single shared column datapath.
REQ-013 FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, in_state SHALL be captured into a work register, column counter cleared to 0, go to BUSY.
REQ-015 BUSY: each cycle column[cnt] SHALL be replaced by its result and cnt incremented; when cnt=3 is written, go to DONE; in_ready=0, in_valid ignored.
REQ-016 Latency: accept on edge N -> out_valid=1 after edge N+4.
REQ-017 DONE: out_valid=1, out_state = work register, held stable while out_ready=0 for any number of cycles.
REQ-018 DONE with out_ready=1 and in_valid=0 -> IDLE, out_valid=0 next cycle.
REQ-019 DONE with out_ready=1: in_ready SHALL be 1; if in_valid=1 simultaneously, the new state SHALL be captured and FSM go directly to BUSY (back-to-back, no bubble).
REQ-020 DONE with out_ready=0: in_ready SHALL be 0.
REQ-021 Column counter SHALL be 2 bits and wrap 3->0 only via a new capture.
REQ-022 out_state SHALL be driven from the work register only; it is don't-care while out_valid=0.

Reset
REQ-023 On rst=1 at an edge: FSM=IDLE, cnt=0, work register=0, out_valid=0, in_ready=1 after that edge.
REQ-024 rst asserted in BUSY or DONE SHALL abandon the operation; no out_valid for the abandoned state.
REQ-025 rst has priority over in_valid and out_ready in the same cycle.

Verification
REQ-026 Single op: in_state=8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> after 4 cycles out_state=db135345_f20a225c_01010101_d4d4d4d5, out_valid=1.
REQ-027 Backpressure: same stimulus, out_ready=0 for 10 cycles -> out_valid and out_state stable, in_ready=0 throughout; accepted on first out_ready=1.
REQ-028 Back-to-back: second state 4d7ebdf8 x4 offered with in_valid=1 as first result drains -> captured that cycle, out_state=2d26314c x4 four cycles later.
REQ-029 Reset mid-op: rst pulsed during cycle 2 of BUSY -> out_valid stays 0, in_ready=1 next cycle, next op correct.
REQ-030 Round trip: 1000 random states through MixColumns model then this block -> output equals original; in_valid in BUSY ignored.

Source files
------------

// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - AES InvMixColumns, one column per cycle through a shared datapath
module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [127:0]  work;
  logic [31:0]   col_in;
  logic [31:0]   col_out;
  logic          accept;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mb(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] md(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] me(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
            m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
            md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
            mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)};
  endfunction

  always_comb begin
    col_in = work[127:96];
    case (cnt)
      2'd0: col_in = work[127:96];
      2'd1: col_in = work[95:64];
      2'd2: col_in = work[63:32];
      2'd3: col_in = work[31:0];
      default: col_in = work[127:96];
    endcase
  end

  assign col_out   = inv_col(col_in);
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_state = work;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      work      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work  <= in_state;
            cnt   <= 2'd0;
            state <= BUSY;
          end
        end
        BUSY: begin
          case (cnt)
            2'd0: work[127:96] <= col_out;
            2'd1: work[95:64]  <= col_out;
            2'd2: work[63:32]  <= col_out;
            2'd3: work[31:0]   <= col_out;
            default: work[127:96] <= col_out;
          endcase
          // cnt parks at 3 in DONE; only a fresh capture clears it
          if (cnt == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work  <= in_state;
              cnt   <= 2'd0;
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - directed and round-trip bench for inv_mix_columns_seq
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] sb[$];

  localparam logic [127:0] VEC_A   = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] VEC_A_X = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] VEC_B   = 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8;
  localparam logic [127:0] VEC_B_X = 128'h2d26314c_2d26314c_2d26314c_2d26314c;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] dbl(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
  endfunction

  function automatic logic [127:0] mix_fwd(input logic [127:0] s);
    logic [127:0] r;
    logic [31:0]  c;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      c  = s[127 - 32*k -: 32];
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      r[127 - 32*k -: 32] = {dbl(a0) ^ dbl(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ dbl(a1) ^ dbl(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ dbl(a2) ^ dbl(a3) ^ a3,
                             dbl(a0) ^ a0 ^ a1 ^ a2 ^ dbl(a3)};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold in_valid until the DUT takes the state, queueing its expected result
  task automatic offer(input logic [127:0] st, input logic [127:0] ex);
    bit taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    in_state = st;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(ex);
        taken = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!taken) chk("offer_timeout", 128'd0, 128'd1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_output: observed %h expected no output", out_state);
      end
      if (sb.size() > 0) chk("scoreboard", out_state, sb.pop_front());
    end
  end

  initial begin
    logic [127:0] orig, mixed;
    int done_cnt, cycles;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_work", out_state, 128'd0);

    // single operation, latency 4
    out_ready = 1'b1;
    offer(VEC_A, VEC_A_X);
    chk("busy_in_ready", 128'(in_ready), 128'd0);
    for (int i = 0; i < 3; i++) begin
      chk("latency_out_valid_low", 128'(out_valid), 128'd0);
      step();
    end
    chk("latency_out_valid_low", 128'(out_valid), 128'd0);
    step();
    chk("single_out_valid", 128'(out_valid), 128'd1);
    chk("single_out_state", out_state, VEC_A_X);
    step();
    chk("drain_out_valid", 128'(out_valid), 128'd0);
    chk("drain_in_ready", 128'(in_ready), 128'd1);

    // backpressure
    out_ready = 1'b0;
    offer(VEC_A, VEC_A_X);
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_state", out_state, VEC_A_X);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    step();
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);

    // back-to-back
    offer(VEC_A, VEC_A_X);
    repeat (4) step();
    in_valid = 1'b1;
    in_state = VEC_B;
    #1;
    chk("b2b_in_ready", 128'(in_ready), 128'd1);
    chk("b2b_out_valid", 128'(out_valid), 128'd1);
    offer(VEC_B, VEC_B_X);
    chk("b2b_captured", 128'(in_ready), 128'd0);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_out_valid_low", 128'(out_valid), 128'd0);
      step();
    end
    step();
    chk("b2b_out_valid", 128'(out_valid), 128'd1);
    chk("b2b_out_state", out_state, VEC_B_X);
    step();

    // reset during the second BUSY cycle
    offer(VEC_A, VEC_A_X);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
    chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
    chk("rst_mid_work", out_state, 128'd0);
    repeat (5) step();
    chk("rst_mid_no_output", 128'(out_valid), 128'd0);
    offer(VEC_A, VEC_A_X);
    repeat (4) step();
    chk("after_rst_out_state", out_state, VEC_A_X);
    step();

    // round trip with random backpressure and ignored offers while busy
    done_cnt = 0;
    cycles   = 0;
    orig     = {$urandom, $urandom, $urandom, $urandom};
    mixed    = mix_fwd(orig);
    while (done_cnt < 1000 && cycles < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      in_valid = 1'b1;
      in_state = in_ready ? mixed : {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(orig);
        done_cnt++;
        orig  = {$urandom, $urandom, $urandom, $urandom};
        mixed = mix_fwd(orig);
      end
      step();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    chk("roundtrip_count", 128'(done_cnt), 128'd1000);
    chk("roundtrip_drained", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
